// File: rtl/dtim_arbiter.sv
// dtim_arbiter: shares one single-port DTIM between the core (r0) and the loader (r1).
// Latency: grant is combinational; the response strobe and read data follow one cycle after the accept.
// Backpressure: the losing requester sees ready=0 and holds its request. Under fixed priority, r1 is force-granted after STARVE_LIMIT blocked cycles.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   r0_* / r1_*        request valid/addr/wmask/wdata in; ready, rvalid, rdata out
//   dtim_o_*           muxed access to the DTIM
//   dtim_i_rdata       DTIM read data, one cycle after the access
//
// Build option: define DTIM_ARB_RR_EN to replace fixed priority with round-robin.
// This option drops the starvation counter.
module dtim_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_i_valid,
  input  logic [ADDR_W-1:0]   r0_i_addr,
  input  logic [DATA_W/8-1:0] r0_i_wmask,
  input  logic [DATA_W-1:0]   r0_i_wdata,
  output logic                r0_o_ready,
  output logic                r0_o_rvalid,
  output logic [DATA_W-1:0]   r0_o_rdata,
  input  logic                r1_i_valid,
  input  logic [ADDR_W-1:0]   r1_i_addr,
  input  logic [DATA_W/8-1:0] r1_i_wmask,
  input  logic [DATA_W-1:0]   r1_i_wdata,
  output logic                r1_o_ready,
  output logic                r1_o_rvalid,
  output logic [DATA_W-1:0]   r1_o_rdata,
  output logic                dtim_o_valid,
  output logic [ADDR_W-1:0]   dtim_o_addr,
  output logic [DATA_W/8-1:0] dtim_o_wmask,
  output logic [DATA_W-1:0]   dtim_o_wdata,
  input  logic [DATA_W-1:0]   dtim_i_rdata
);

  logic gnt0, gnt1;
  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;

`ifdef DTIM_ARB_RR_EN
  // last_gnt_q: 1 = r1 won last, so r0 wins the next contention.
  logic last_gnt_q, last_gnt_d;

  // Grants are gated with rst so ready/valid read 0 during reset, even though the requests are live.
  assign gnt1 = rst & r1_i_valid & (~r0_i_valid | ~last_gnt_q);
  assign gnt0 = rst & r0_i_valid & ~gnt1;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt1)      last_gnt_d = 1'b1;
    else if (gnt0) last_gnt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_gnt_q <= 1'b1;
    else      last_gnt_q <= last_gnt_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign gnt1 = rst & r1_i_valid & (~r0_i_valid | (starve_cnt_q == LIMIT));
  assign gnt0 = rst & r0_i_valid & ~gnt1;

  // The counter counts cycles in which r1 waits behind r0.
  // It holds at LIMIT until the forced grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!r1_i_valid || gnt1)     starve_cnt_d = 4'd0;
    else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt_q <= 4'd0;
    else      starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign r0_o_ready   = gnt0;
  assign r1_o_ready   = gnt1;
  assign dtim_o_valid = gnt0 | gnt1;

  always_comb begin
    dtim_o_addr  = '0;
    dtim_o_wmask = '0;
    dtim_o_wdata = '0;
    if (gnt1) begin
      dtim_o_addr  = r1_i_addr;
      dtim_o_wmask = r1_i_wmask;
      dtim_o_wdata = r1_i_wdata;
    end else if (gnt0) begin
      dtim_o_addr  = r0_i_addr;
      dtim_o_wmask = r0_i_wmask;
      dtim_o_wdata = r0_i_wdata;
    end
  end

  // Only one access is in flight at a time, so a single owner bit keeps each requester's responses in order.
  assign resp_valid_d = gnt0 | gnt1;
  assign resp_owner_d = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign r0_o_rvalid = resp_valid_q & ~resp_owner_q;
  assign r1_o_rvalid = resp_valid_q &  resp_owner_q;
  assign r0_o_rdata  = r0_o_rvalid ? dtim_i_rdata : '0;
  assign r1_o_rdata  = r1_o_rvalid ? dtim_i_rdata : '0;

endmodule
